// File: rtl/cvxif_copro_pkg.sv
// Shared definitions for the CV-X-IF reference coprocessor.
// Holds the custom-0 opcode/funct3 encodings, the operation enum, the
// pending-instruction FIFO entry and the registered result record.
package cvxif_copro_pkg;

    localparam int unsigned CVX_XLEN = 32;
    localparam int unsigned CVX_ID_W = 4;

    localparam logic [6:0] OPCODE_CUSTOM0  = 7'b0001011;
    localparam logic [2:0] F3_CUS_ADD      = 3'b000;
    localparam logic [2:0] F3_CUS_NOP      = 3'b001;
    localparam logic [2:0] F3_CUS_MADD     = 3'b010;
    localparam logic [2:0] F3_CUS_EXC      = 3'b011;
    localparam logic [5:0] EXCCODE_ILLEGAL = 6'd2;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_NOP  = 2'd1,
        OP_MADD = 2'd2,
        OP_EXC  = 2'd3
    } op_e;

    typedef struct packed {
        logic [CVX_ID_W-1:0] id;
        op_e                 op;
        logic [4:0]          rd;
        logic [CVX_XLEN-1:0] rs1;
        logic [CVX_XLEN-1:0] rs2;
        logic                committed;
        logic                killed;
    } entry_t;

    typedef struct packed {
        logic [CVX_ID_W-1:0] id;
        logic [CVX_XLEN-1:0] data;
        logic [4:0]          rd;
        logic                we;
        logic                exc;
        logic [5:0]          exccode;
    } result_t;

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Combinational decoder for the custom-0 coprocessor instruction set.
// Ports:
//   instr_i      32-bit instruction word
//   accept_o     instruction belongs to this coprocessor
//   writeback_o  accepted instruction will write rd
//   op_o         decoded operation
//   rs_needed_o  source operands required (bit0 = rs1, bit1 = rs2)
//   rd_o         destination register field
module cvxif_copro_decoder
    import cvxif_copro_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        accept_o,
    output logic        writeback_o,
    output op_e         op_o,
    output logic [1:0]  rs_needed_o,
    output logic [4:0]  rd_o
);

    always_comb begin
        accept_o    = 1'b0;
        writeback_o = 1'b0;
        op_o        = OP_NOP;
        rs_needed_o = '0;
        rd_o        = instr_i[11:7];
        if (instr_i[6:0] == OPCODE_CUSTOM0 && instr_i[31:25] == 7'd0) begin
            case (instr_i[14:12])
                F3_CUS_ADD: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    op_o        = OP_ADD;
                    rs_needed_o = 2'b11;
                end
                F3_CUS_NOP: begin
                    accept_o = 1'b1;
                    op_o     = OP_NOP;
                end
                F3_CUS_MADD: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    op_o        = OP_MADD;
                    rs_needed_o = 2'b11;
                end
                F3_CUS_EXC: begin
                    accept_o    = 1'b1;
                    op_o        = OP_EXC;
                    rs_needed_o = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: decodes custom-0 instructions, queues accepted ones
// until the core commits or kills them, executes committed ones in issue
// order and returns results over a valid/ready channel.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   x_issue_*                    issue request/response (valid/ready)
//   x_commit_*                   commit/kill strobe by instruction id
//   x_result_*                   result channel (valid/ready)
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN              = CVX_XLEN,
    parameter int unsigned IdWidth           = CVX_ID_W,
    parameter int unsigned QueueDepth        = 4,
    parameter int unsigned MultiCycleLatency = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               x_issue_valid_i,
    output logic               x_issue_ready_o,
    input  logic [31:0]        x_issue_instr_i,
    input  logic [IdWidth-1:0] x_issue_id_i,
    input  logic [XLEN-1:0]    x_issue_rs1_i,
    input  logic [XLEN-1:0]    x_issue_rs2_i,
    input  logic [1:0]         x_issue_rs_valid_i,
    output logic               x_issue_accept_o,
    output logic               x_issue_writeback_o,
    input  logic               x_commit_valid_i,
    input  logic [IdWidth-1:0] x_commit_id_i,
    input  logic               x_commit_kill_i,
    output logic               x_result_valid_o,
    input  logic               x_result_ready_i,
    output logic [IdWidth-1:0] x_result_id_o,
    output logic [XLEN-1:0]    x_result_data_o,
    output logic [4:0]         x_result_rd_o,
    output logic               x_result_we_o,
    output logic               x_result_exc_o,
    output logic [5:0]         x_result_exccode_o
);

    // entry_t/result_t are sized from the package widths, so XLEN and
    // IdWidth must stay at their package defaults.
    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned CntW = $clog2(MultiCycleLatency + 1);
    localparam logic [CntW-1:0] CNT_LOAD = CntW'(MultiCycleLatency - 1);
    localparam logic [PtrW:0]   FULL_CNT = (PtrW + 1)'(QueueDepth);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    result_t             res_q, res_d;
    entry_t              mem_q [QueueDepth];
    logic [QueueDepth-1:0] vld_q;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic                full;
    logic                push, pop;
    entry_t              new_entry, head;
    logic                commit_hit_new;

    logic       dec_accept, dec_writeback;
    op_e        dec_op;
    logic [1:0] dec_needed;
    logic [4:0] dec_rd;

    cvxif_copro_decoder u_decoder (
        .instr_i     (x_issue_instr_i),
        .accept_o    (dec_accept),
        .writeback_o (dec_writeback),
        .op_o        (dec_op),
        .rs_needed_o (dec_needed),
        .rd_o        (dec_rd)
    );

    function automatic result_t make_result(input entry_t e);
        result_t r;
        r.id   = e.id;
        r.rd   = e.rd;
        if (e.op == OP_EXC) begin
            r.data    = '0;
            r.we      = 1'b0;
            r.exc     = 1'b1;
            r.exccode = EXCCODE_ILLEGAL;
        end else begin
            r.data    = e.rs1 + e.rs2;
            r.we      = 1'b1;
            r.exc     = 1'b0;
            r.exccode = '0;
        end
        return r;
    endfunction

    // Full is taken from the registered occupancy, so a pop only frees
    // its slot for issue in the following cycle.
    assign full                = (count_q == FULL_CNT);
    assign x_issue_accept_o    = dec_accept;
    assign x_issue_writeback_o = dec_writeback;
    assign x_issue_ready_o     = !rst_i && !full &&
                                 (!dec_accept || ((x_issue_rs_valid_i & dec_needed) == dec_needed));
    assign push                = x_issue_valid_i && x_issue_ready_o && dec_accept;
    assign head                = mem_q[rd_ptr_q];

    // A commit arriving with the issue of the same id applies to the new entry.
    assign commit_hit_new = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);

    always_comb begin
        new_entry           = '0;
        new_entry.id        = x_issue_id_i;
        new_entry.op        = dec_op;
        new_entry.rd        = dec_rd;
        new_entry.rs1       = x_issue_rs1_i;
        new_entry.rs2       = x_issue_rs2_i;
        new_entry.committed = commit_hit_new;
        new_entry.killed    = commit_hit_new && x_commit_kill_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vld_q[rd_ptr_q] && head.committed) begin
                    if (head.killed || head.op == OP_NOP) begin
                        pop = 1'b1;
                    end else if (head.op == OP_MADD) begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_BUSY;
                    end else begin
                        res_d   = make_result(head);
                        state_d = S_RESP;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    res_d   = make_result(head);
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (x_result_ready_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            for (int unsigned i = 0; i < QueueDepth; i++) begin
                if (pop && PtrW'(i) == rd_ptr_q)  vld_q[i] <= 1'b0;
                if (push && PtrW'(i) == wr_ptr_q) vld_q[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < QueueDepth; i++) begin
            if (push && PtrW'(i) == wr_ptr_q) begin
                mem_q[i] <= new_entry;
            end else if (x_commit_valid_i && vld_q[i] && mem_q[i].id == x_commit_id_i) begin
                mem_q[i].committed <= 1'b1;
                mem_q[i].killed    <= x_commit_kill_i;
            end
        end
    end

    assign x_result_valid_o   = (state_q == S_RESP);
    assign x_result_id_o      = res_q.id;
    assign x_result_data_o    = res_q.data;
    assign x_result_rd_o      = res_q.rd;
    assign x_result_we_o      = res_q.we;
    assign x_result_exc_o     = res_q.exc;
    assign x_result_exccode_o = res_q.exccode;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
module tb_cvxif_copro_responder;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IDW  = 4;
    localparam int unsigned LAT  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            x_issue_valid_i = 1'b0;
    logic            x_issue_ready_o;
    logic [31:0]     x_issue_instr_i = '0;
    logic [IDW-1:0]  x_issue_id_i = '0;
    logic [XLEN-1:0] x_issue_rs1_i = '0;
    logic [XLEN-1:0] x_issue_rs2_i = '0;
    logic [1:0]      x_issue_rs_valid_i = '0;
    logic            x_issue_accept_o;
    logic            x_issue_writeback_o;
    logic            x_commit_valid_i = 1'b0;
    logic [IDW-1:0]  x_commit_id_i = '0;
    logic            x_commit_kill_i = 1'b0;
    logic            x_result_valid_o;
    logic            x_result_ready_i = 1'b0;
    logic [IDW-1:0]  x_result_id_o;
    logic [XLEN-1:0] x_result_data_o;
    logic [4:0]      x_result_rd_o;
    logic            x_result_we_o;
    logic            x_result_exc_o;
    logic [5:0]      x_result_exccode_o;

    always #5 clk = ~clk;

    cvxif_copro_responder #(
        .XLEN(XLEN), .IdWidth(IDW), .QueueDepth(4), .MultiCycleLatency(LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
        .x_issue_instr_i(x_issue_instr_i), .x_issue_id_i(x_issue_id_i),
        .x_issue_rs1_i(x_issue_rs1_i), .x_issue_rs2_i(x_issue_rs2_i),
        .x_issue_rs_valid_i(x_issue_rs_valid_i),
        .x_issue_accept_o(x_issue_accept_o), .x_issue_writeback_o(x_issue_writeback_o),
        .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
        .x_commit_kill_i(x_commit_kill_i),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
        .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o),
        .x_result_exc_o(x_result_exc_o), .x_result_exccode_o(x_result_exccode_o)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: op 0=ADD 1=NOP 2=MADD 3=EXC
    typedef struct {
        int          id;
        int          op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        bit          committed;
        bit          killed;
    } mentry_t;

    mentry_t mq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] ins, output bit acc, output bit wb, output int op);
        int f3;
        acc = 0; wb = 0; op = 1;
        f3 = int'(ins[14:12]);
        if (ins[6:0] == 7'h0B && ins[31:25] == 7'd0 && f3 < 4) begin
            acc = 1;
            op  = f3;
            wb  = (f3 == 0 || f3 == 2);
        end
    endfunction

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [31:0] w;
        k = int'($urandom_range(0, 5));
        w = $urandom;
        w[31:25] = 7'd0;
        w[6:0]   = 7'h0B;
        if (k < 4) w[14:12] = 3'(k);
        else if (k == 4) w[14:12] = 3'($urandom_range(4, 7));
        else w[6:0] = 7'h33;
        return w;
    endfunction

    function automatic void model_commit(input int id, input bit kill);
        foreach (mq[i]) begin
            if (mq[i].id == id) begin
                mq[i].committed = 1;
                mq[i].killed    = kill;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [31:0] ins, input int id, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] rsv);
        bit acc, wb;
        int op, k;
        mentry_t e;
        decode(ins, acc, wb, op);
        x_issue_valid_i    = 1'b1;
        x_issue_instr_i    = ins;
        x_issue_id_i       = IDW'(id);
        x_issue_rs1_i      = a;
        x_issue_rs2_i      = b;
        x_issue_rs_valid_i = rsv;
        #1;
        chk("issue_accept", 32'(x_issue_accept_o), 32'(acc));
        chk("issue_writeback", 32'(x_issue_writeback_o), 32'(wb));
        k = 0;
        while (!x_issue_ready_o && k < 20) begin
            cyc();
            k++;
        end
        if (x_issue_ready_o) begin
            @(posedge clk);
            if (acc) begin
                e.id = id; e.op = op; e.rd = ins[11:7]; e.a = a; e.b = b;
                e.committed = 0; e.killed = 0;
                mq.push_back(e);
            end
            #1;
        end else begin
            chk("issue_ready_timeout", 32'(x_issue_ready_o), 32'd1);
        end
        x_issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input int id, input bit kill);
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = IDW'(id);
        x_commit_kill_i  = kill;
        @(posedge clk);
        model_commit(id, kill);
        #1;
        x_commit_valid_i = 1'b0;
        x_commit_kill_i  = 1'b0;
    endtask

    task automatic probe_ready(input string tag, input logic [31:0] ins, input logic [1:0] rsv,
                               input logic exp);
        x_issue_valid_i    = 1'b0;
        x_issue_instr_i    = ins;
        x_issue_rs_valid_i = rsv;
        #1;
        chk(tag, 32'(x_issue_ready_o), 32'(exp));
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!x_result_valid_o && n < max) begin
            cyc();
            n++;
        end
    endtask

    task automatic chk_result(input string tag, input mentry_t e);
        logic [31:0] d;
        d = (e.op == 3) ? 32'd0 : e.a + e.b;
        chk({tag, "_id"}, 32'(x_result_id_o), 32'(e.id));
        chk({tag, "_data"}, x_result_data_o, d);
        chk({tag, "_rd"}, 32'(x_result_rd_o), 32'(e.rd));
        chk({tag, "_we"}, 32'(x_result_we_o), (e.op == 3) ? 32'd0 : 32'd1);
        chk({tag, "_exc"}, 32'(x_result_exc_o), (e.op == 3) ? 32'd1 : 32'd0);
        chk({tag, "_exccode"}, 32'(x_result_exccode_o), (e.op == 3) ? 32'd2 : 32'd0);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk(tag, 32'(x_result_valid_o), 32'd0);
        end
    endtask

    // Every model entry must be committed; results leave in issue order,
    // skipping killed entries and NOPs.
    task automatic drain(input string tag);
        mentry_t exp_q[$];
        int c;
        bit r;
        foreach (mq[i]) if (!mq[i].killed && mq[i].op != 1) exp_q.push_back(mq[i]);
        mq.delete();
        c = 0;
        while (exp_q.size() > 0 && c < 300) begin
            r = 1'($urandom_range(0, 1));
            x_result_ready_i = r;
            #1;
            if (x_result_valid_o && r) begin
                chk_result(tag, exp_q[0]);
                void'(exp_q.pop_front());
            end
            cyc();
            c++;
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        x_result_ready_i = 1'b0;
        idle_check({tag, "_idle"}, 4);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, cnt, start;
        int ids[4];
        logic [31:0] add_w, ins;
        mentry_t e;

        add_w = mk_instr(7'd0, 3'b000, 5'd10, 7'h0B);

        // Reset state
        repeat (3) cyc();
        probe_ready("reset_ready", add_w, 2'b11, 1'b0);
        chk("reset_valid", 32'(x_result_valid_o), 32'd0);
        chk("reset_data", x_result_data_o, 32'd0);
        chk("reset_exccode", 32'(x_result_exccode_o), 32'd0);
        cyc();
        rst = 1'b0;
        probe_ready("post_reset_ready", add_w, 2'b11, 1'b1);

        // ADD id 3: 5 + 7, commit next cycle, result one cycle after commit
        cyc();
        drive_issue(add_w, 3, 32'd5, 32'd7, 2'b11);
        do_commit(3, 0);
        x_result_ready_i = 1'b1;
        wait_valid(10, n);
        chk("add_latency", 32'(n), 32'd1);
        chk_result("add", mq[0]);
        chk("add_data_abs", x_result_data_o, 32'd12);
        void'(mq.pop_front());
        cyc();
        chk("add_popped", 32'(x_result_valid_o), 32'd0);
        x_result_ready_i = 1'b0;

        // MADD with wrap-around, held while result_ready is low
        drive_issue(mk_instr(7'd0, 3'b010, 5'd4, 7'h0B), 9, 32'hFFFF_FFFF, 32'd2, 2'b11);
        do_commit(9, 0);
        wait_valid(20, n);
        chk("madd_latency", 32'(n), 32'(LAT + 1));
        chk("madd_data_abs", x_result_data_o, 32'h0000_0001);
        chk_result("madd", mq[0]);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("madd_hold_valid", 32'(x_result_valid_o), 32'd1);
            chk("madd_hold_data", x_result_data_o, 32'h0000_0001);
            chk("madd_hold_id", 32'(x_result_id_o), 32'd9);
        end
        x_result_ready_i = 1'b1;
        cyc();
        chk("madd_popped", 32'(x_result_valid_o), 32'd0);
        x_result_ready_i = 1'b0;
        void'(mq.pop_front());

        // Fill the queue with four uncommitted ADDs
        for (int i = 0; i < 4; i++) drive_issue(add_w, i, $urandom, $urandom, 2'b11);
        probe_ready("full_ready", add_w, 2'b11, 1'b0);
        do_commit(0, 0);
        x_result_ready_i = 1'b1;
        wait_valid(10, n);
        chk("full_head_latency", 32'(n), 32'd1);
        chk_result("full_head", mq[0]);
        void'(mq.pop_front());
        cyc();
        x_result_ready_i = 1'b0;
        probe_ready("slot_freed", add_w, 2'b11, 1'b1);
        for (int i = 1; i < 4; i++) do_commit(i, 0);
        drain("full_rest");

        // Killed ADD leaves no result; the next ADD completes
        drive_issue(add_w, 5, $urandom, $urandom, 2'b11);
        do_commit(5, 1);
        idle_check("kill_no_result", 4);
        drive_issue(add_w, 6, $urandom, $urandom, 2'b11);
        do_commit(6, 0);
        drain("after_kill");

        // Foreign and malformed encodings: handshake completes, nothing queued
        probe_ready("foreign_ready", 32'h00B5_0533, 2'b00, 1'b1);
        drive_issue(32'h00B5_0533, 12, 32'd1, 32'd1, 2'b00);
        drive_issue(mk_instr(7'd1, 3'b000, 5'd3, 7'h0B), 13, 32'd1, 32'd1, 2'b11);
        drive_issue(mk_instr(7'd0, 3'b101, 5'd3, 7'h0B), 14, 32'd1, 32'd1, 2'b11);
        chk("foreign_not_queued", 32'(mq.size()), 32'd0);
        do_commit(12, 0);
        idle_check("foreign_no_result", 3);

        // NOP needs no operands; ADD stalls on a missing operand
        ins = mk_instr(7'd0, 3'b001, 5'd7, 7'h0B);
        probe_ready("nop_ready", ins, 2'b00, 1'b1);
        probe_ready("add_rs2_missing", add_w, 2'b01, 1'b0);
        drive_issue(ins, 11, 32'd0, 32'd0, 2'b00);
        do_commit(11, 0);
        // EXC id 2
        drive_issue(mk_instr(7'd0, 3'b011, 5'd9, 7'h0B), 2, $urandom, $urandom, 2'b11);
        do_commit(2, 0);
        drain("nop_exc");

        // Issue and commit id 1 in the same cycle
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = 4'd1;
        x_commit_kill_i  = 1'b0;
        drive_issue(add_w, 1, $urandom, $urandom, 2'b11);
        model_commit(1, 0);
        x_commit_valid_i = 1'b0;
        x_result_ready_i = 1'b1;
        wait_valid(10, n);
        chk("same_cycle_latency", 32'(n), 32'd1);
        chk_result("same_cycle", mq[0]);
        void'(mq.pop_front());
        cyc();
        x_result_ready_i = 1'b0;

        // Reset in the middle of a MADD
        drive_issue(mk_instr(7'd0, 3'b010, 5'd5, 7'h0B), 7, $urandom, $urandom, 2'b11);
        do_commit(7, 0);
        cyc();
        cyc();
        rst = 1'b1;
        probe_ready("mid_reset_ready", add_w, 2'b11, 1'b0);
        cyc();
        chk("mid_reset_valid", 32'(x_result_valid_o), 32'd0);
        chk("mid_reset_data", x_result_data_o, 32'd0);
        chk("mid_reset_id", 32'(x_result_id_o), 32'd0);
        chk("mid_reset_we", 32'(x_result_we_o), 32'd0);
        rst = 1'b0;
        mq.delete();
        idle_check("mid_reset_dropped", 6);
        drive_issue(add_w, 8, $urandom, $urandom, 2'b11);
        do_commit(8, 0);
        drain("post_reset");

        // Randomized rounds: unique ids, shuffled commit order, occasional kill
        for (int round = 0; round < 12; round++) begin
            cnt  = int'($urandom_range(1, 4));
            base = int'($urandom_range(0, 15));
            for (int k = 0; k < cnt; k++) begin
                ids[k] = (base + k) % 16;
                drive_issue(rand_instr(), ids[k], $urandom, $urandom, 2'b11);
            end
            start = int'($urandom_range(0, cnt - 1));
            for (int k = 0; k < cnt; k++)
                do_commit(ids[(start + k) % cnt], ($urandom_range(0, 3) == 0));
            drain("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
